// File: rtl/pr_pkg.sv
// ---------------------------------------------------------------------------
// pr_pkg
// Shared definitions for the priority encode/decode pair. pr_encoder and
// pr_decoder_seq both import this package, so the code width matches at
// both ends of the encoded request bus.
//
// Contents:
//   PR_N       default code width (3 -> 8 one-hot lines)
//   PR_CNT_W   width of the hold/gap down-counter
//   pr_state_t decoder FSM state encoding
//   cnt_load   converts a cycle count into a down-counter load value
// ---------------------------------------------------------------------------
package pr_pkg;

    localparam int PR_N     = 3;
    localparam int PR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } pr_state_t;

    // A phase lasting 'cycles' cycles loads cycles-1, because the zero
    // count itself occupies the final cycle of the phase. A zero-length
    // phase is never entered, so its load value is irrelevant; clamp to 0
    // to keep the constant in range.
    function automatic logic [PR_CNT_W-1:0] cnt_load(input int cycles);
        if (cycles > 0)
            cnt_load = PR_CNT_W'(cycles - 1);
        else
            cnt_load = '0;
    endfunction

endpackage

// File: rtl/pr_decoder_seq_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Loadable down-counter with a zero flag. The decoder reuses one instance
// to time both the HOLD phase and the GAP phase.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, clears the count
//   load        load load_value this cycle (takes priority over counting)
//   load_value  value to load
//   en          decrement enable
//   count       current count
//   zero        count == 0
// ---------------------------------------------------------------------------
module hold_timer
    import pr_pkg::*;
#(
    parameter int W = PR_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    // The count saturates at zero instead of wrapping, so a controller
    // that stays enabled for one more cycle cannot roll it over to all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (en && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pr_decoder_seq.sv
// ---------------------------------------------------------------------------
// pr_decoder_seq
// Sequential binary-to-one-hot decoder. This is the receive-side
// counterpart of pr_encoder. A code is accepted over a valid/ready
// handshake. Its one-hot line is driven for HOLD cycles, followed by GAP
// idle cycles, before the next code can be accepted.
//
// Parameters:
//   N     code width, output width is 2**N
//   HOLD  cycles each line is driven (1..255)
//   GAP   idle cycles after each hold (0..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  a code is presented on in_code
//   in_code   binary code to decode
//   in_ready  block can accept a code this cycle (high only in IDLE)
//   y         registered one-hot decoded lines
//   y_valid   y is carrying a decoded line
//   done      one-cycle pulse on the last HOLD cycle
//   busy      state is not IDLE
// ---------------------------------------------------------------------------
module pr_decoder_seq
    import pr_pkg::*;
#(
    parameter int N    = PR_N,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N-1:0]      in_code,
    output logic              in_ready,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic              done,
    output logic              busy
);

    localparam int W = 2**N;

    localparam logic [PR_CNT_W-1:0] HOLD_LOAD = cnt_load(HOLD);
    localparam logic [PR_CNT_W-1:0] GAP_LOAD  = cnt_load(GAP);
    localparam logic [W-1:0]        LINE0     = W'(1);
    localparam logic                HAS_GAP   = (GAP > 0);
    localparam logic                HOLD_ONE  = (HOLD_LOAD == '0);

    pr_state_t             state;
    logic                  accept;
    logic                  timer_load;
    logic [PR_CNT_W-1:0]   timer_value;
    logic                  timer_en;
    logic [PR_CNT_W-1:0]   count;
    logic                  count_zero;

    // in_ready is a registered output that is set only in IDLE, so it
    // fully qualifies the handshake.
    assign accept = in_valid && in_ready;

    // The timer is loaded with HOLD-1 on accept. It is reloaded with GAP-1
    // on the last DRIVE cycle when a gap follows. Otherwise it counts down
    // while the block is busy.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = HOLD_LOAD;
        if (accept) begin
            timer_load  = 1'b1;
            timer_value = HOLD_LOAD;
        end else if ((state == ST_DRIVE) && count_zero && HAS_GAP) begin
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
        end
    end

    assign timer_en = (state != ST_IDLE);

    hold_timer #(
        .W (PR_CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .en         (timer_en),
        .count      (count),
        .zero       (count_zero)
    );

    // Control FSM and output registers. All outputs are registered. done is
    // set one edge early, when the count is about to reach zero, so that it
    // coincides with the last HOLD cycle. The y register holds the decoded
    // line, so the accepted code needs no separate storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            y        <= '0;
            y_valid  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state    <= ST_DRIVE;
                        y        <= LINE0 << in_code;
                        y_valid  <= 1'b1;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        done     <= HOLD_ONE;
                    end
                end

                ST_DRIVE: begin
                    if (count_zero) begin
                        y       <= '0;
                        y_valid <= 1'b0;
                        done    <= 1'b0;
                        if (HAS_GAP) begin
                            state <= ST_GAP;
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        done <= (count == PR_CNT_W'(1));
                    end
                end

                ST_GAP: begin
                    done <= 1'b0;
                    if (count_zero) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    y        <= '0;
                    y_valid  <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pr_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_pr_decoder_seq
// Directed bench for pr_decoder_seq. The dut instance uses HOLD=4, GAP=1.
// The dut1 instance uses HOLD=1, GAP=0. Observed outputs are packed as
// {y, y_valid, done, busy, in_ready} and compared after each clock edge.
// ---------------------------------------------------------------------------
module tb_pr_decoder_seq;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       done;
    logic       busy;

    logic       in_valid1;
    logic [2:0] in_code1;
    logic       in_ready1;
    logic [7:0] y1;
    logic       y_valid1;
    logic       done1;
    logic       busy1;

    int tests;
    int fails;

    pr_decoder_seq #(.N(3), .HOLD(4), .GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .done     (done),
        .busy     (busy)
    );

    pr_decoder_seq #(.N(3), .HOLD(1), .GAP(0)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_code  (in_code1),
        .in_ready (in_ready1),
        .y        (y1),
        .y_valid  (y_valid1),
        .done     (done1),
        .busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle 1 time unit so that registered
    // outputs are stable and any new inputs are set well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference priority encoder that stands in for pr_encoder in the
    // loopback test. It returns the index of the highest set bit.
    function automatic logic [2:0] prio_enc(input logic [7:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (d[i]) r = 3'(i);
        return r;
    endfunction

    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b1;
        in_valid = 1'b0; in_code = 3'd0;
        in_valid1 = 1'b0; in_code1 = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 12'h001);
        end
        obs = {y1, y_valid1, done1, busy1, in_ready1};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL reset_state_dut1: got %h expected %h", obs, 12'h001);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {y, y_valid, done, busy, in_ready};
            tests++;
            if (obs !== 12'h001) begin
                fails++;
                $display("[TB] FAIL idle_cycle%0d: got %h expected %h", i, obs, 12'h001);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  lines [8];
        logic [11:0] obs;
        logic [11:0] exp;
        lines = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int c = 0; c < 8; c++) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL sweep_ready_code%0d: got %b expected 1", c, in_ready);
            end
            in_valid = 1'b1;
            in_code  = 3'(c);
            tick();
            in_valid = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                obs = {y, y_valid, done, busy, in_ready};
                exp = {lines[c], 1'b1, (i == 4), 1'b1, 1'b0};
                tests++;
                if (obs !== exp) begin
                    fails++;
                    $display("[TB] FAIL sweep_code%0d_hold%0d: got %h expected %h", c, i, obs, exp);
                end
                tick();
            end
            obs = {y, y_valid, done, busy, in_ready};
            tests++;
            if (obs !== 12'h002) begin
                fails++;
                $display("[TB] FAIL sweep_code%0d_gap: got %h expected %h", c, obs, 12'h002);
            end
            tick();
            obs = {y, y_valid, done, busy, in_ready};
            tests++;
            if (obs !== 12'h001) begin
                fails++;
                $display("[TB] FAIL sweep_code%0d_ready: got %h expected %h", c, obs, 12'h001);
            end
        end
    endtask

    task automatic test_held_valid();
        logic [11:0] obs;
        logic [11:0] exp;
        int n;
        in_valid = 1'b1;
        in_code  = 3'd5;
        tick();
        in_code  = 3'd2;
        for (int i = 1; i <= 4; i++) begin
            obs = {y, y_valid, done, busy, in_ready};
            exp = {8'h20, 1'b1, (i == 4), 1'b1, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL held_code5_hold%0d: got %h expected %h", i, obs, exp);
            end
            tick();
        end
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== 12'h002) begin
            fails++;
            $display("[TB] FAIL held_gap: got %h expected %h", obs, 12'h002);
        end
        tick();
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL held_ready: got %h expected %h", obs, 12'h001);
        end
        tick();
        in_valid = 1'b0;
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== {8'h04, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL held_code2: got %h expected %h", obs, {8'h04, 4'b1010});
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL held_timeout: in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] obs;
        in_valid = 1'b1;
        in_code  = 3'd7;
        tick();
        in_valid = 1'b0;
        tick();
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== {8'h80, 4'b1010}) begin
            fails++;
            $display("[TB] FAIL midrst_drive2: got %h expected %h", obs, {8'h80, 4'b1010});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL midrst_after: got %h expected %h", obs, 12'h001);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            obs = {y, y_valid, done, busy, in_ready};
            tests++;
            if (obs !== 12'h001) begin
                fails++;
                $display("[TB] FAIL midrst_quiet%0d: got %h expected %h", i, obs, 12'h001);
            end
        end
    endtask

    task automatic test_hold1_gap0();
        logic [11:0] obs;
        in_valid1 = 1'b1;
        in_code1  = 3'd3;
        tick();
        in_code1  = 3'd6;
        obs = {y1, y_valid1, done1, busy1, in_ready1};
        tests++;
        if (obs !== {8'h08, 4'b1110}) begin
            fails++;
            $display("[TB] FAIL h1_code3: got %h expected %h", obs, {8'h08, 4'b1110});
        end
        tick();
        obs = {y1, y_valid1, done1, busy1, in_ready1};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL h1_idle: got %h expected %h", obs, 12'h001);
        end
        tick();
        in_valid1 = 1'b0;
        obs = {y1, y_valid1, done1, busy1, in_ready1};
        tests++;
        if (obs !== {8'h40, 4'b1110}) begin
            fails++;
            $display("[TB] FAIL h1_code6: got %h expected %h", obs, {8'h40, 4'b1110});
        end
        tick();
        obs = {y1, y_valid1, done1, busy1, in_ready1};
        tests++;
        if (obs !== 12'h001) begin
            fails++;
            $display("[TB] FAIL h1_end: got %h expected %h", obs, 12'h001);
        end
    endtask

    task automatic test_loopback();
        logic [11:0] obs;
        logic [11:0] exp;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL loop_ready: got %b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_code  = prio_enc(8'b00100100);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            obs = {y, y_valid, done, busy, in_ready};
            exp = {8'h20, 1'b1, (i == 4), 1'b1, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL loop_hold%0d: got %h expected %h", i, obs, exp);
            end
            tick();
        end
        obs = {y, y_valid, done, busy, in_ready};
        tests++;
        if (obs !== 12'h002) begin
            fails++;
            $display("[TB] FAIL loop_gap: got %h expected %h", obs, 12'h002);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        in_valid = 1'b0; in_code = 3'd0;
        in_valid1 = 1'b0; in_code1 = 3'd0;
        test_reset();
        test_sweep();
        test_held_valid();
        test_reset_mid();
        test_hold1_gap0();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
